// File: rtl/ifetch_queue.sv
// Instruction fetch front end: single-outstanding imem requests, small FIFO to decode, flush/redirect.
// Optional IFQ_BYPASS_EN: when the FIFO is empty, a kept response is forwarded to decode in the same cycle.
module ifetch_queue #(
  parameter int unsigned        DEPTH    = 4,
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [DATA_W-1:0] mem_instr [DEPTH];
  logic [ADDR_W-1:0] mem_pc    [DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic req_fire;
  logic byp;
  logic push;
  logic pop;
  logic redirect_pc_unused;

  assign redirect_pc_unused = ^redirect_pc[1:0];

  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == FULL_CNT);
    req_fire   = (state == IDLE) && !fifo_full && !redirect_valid && !reset;
`ifdef IFQ_BYPASS_EN
    byp        = fifo_empty && (state == REQ) && imem_rvalid && !redirect_valid && !reset;
`else
    byp        = 1'b0;
`endif
    pop        = !fifo_empty && out_ready && !redirect_valid && !reset;
    // A bypassed word taken by decode this cycle never enters the FIFO.
    push       = (state == REQ) && imem_rvalid && !redirect_valid && !reset && !(byp && out_ready);

    imem_req   = req_fire;
    imem_addr  = fetch_pc;
    out_valid  = !fifo_empty || byp;
    out_instr  = byp ? imem_rdata : mem_instr[rd_ptr];
    out_pc     = byp ? req_pc     : mem_pc[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_instr[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr]    <= req_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      // An outstanding request whose data has not yet arrived must be dropped.
      case (state)
        IDLE:    state <= IDLE;
        REQ,
        DROP:    state <= imem_rvalid ? IDLE : DROP;
        default: state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + ADDR_W'(4);
            state    <= REQ;
          end
        end
        REQ:     if (imem_rvalid) state <= IDLE;
        DROP:    if (imem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
